display_arbiter: RTL and testbench
==================================

# display_arbiter

Round-robin arbiter that shares the single 4-digit hex display between `N_REQ` requesters (register viewer, debug port, status monitor, ...). It sits in front of `hex_display` and drives its 16-bit `data` input. Each grant is held for a minimum dwell time so the value stays readable. A one-hot grant vector is returned so every requester knows when it owns the display.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `HOLD_CYCLES`, 1000: minimum ownership time in `clk` cycles, at least 1.
- `clk`  in  1: system clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  N_REQ: request level per requester; high means it wants the display.
- `req_data`  in  16*N_REQ: flattened data; requester i uses bits [16i+15:16i].
- `grant`  out  N_REQ: one-hot owner indicator, registered.
- `owner_id`  out  clog2(N_REQ): index of current or last owner, registered.
- `busy`  out  1: high while a requester owns the display.
- `disp_data`  out  16: value for `hex_display.data`, registered.

## Operation
- Reset values:
  - `grant`=0, `owner_id`=0, `busy`=0, `disp_data`=16'h0000.
  - Hold counter = 0.
  - Round-robin pointer `last` = N_REQ-1, so the first search starts at index 0.
- States: IDLE and OWN.
- IDLE:
  - If any `req` is high, grant the first asserted index searching `last+1, last+2, ...` modulo N_REQ.
  - On the grant: go to OWN, load the counter with HOLD_CYCLES-1, and set `last`=winner.
  - If no `req` is high, stay in IDLE; `disp_data` holds its last value.
- OWN, counter > 0:
  - Decrement the counter each cycle.
  - The owner keeps the display whatever any `req` does.
- OWN, counter == 0:
  - Another requester asserted: switch to the next asserted index in round-robin order after the owner. Reload the counter and update `last`.
  - Otherwise, owner `req` still high: stay in OWN with the counter at 0.
  - Otherwise: go to IDLE; `grant`=0, `busy`=0.
- Data path:
  - While the owner's `req` is high, `disp_data` follows the owner's `req_data` slice.
  - While the owner's `req` is low (dropped early, or in IDLE), `disp_data` freezes at its last value.
- Exactly one `grant` bit is high in OWN and none in IDLE. `busy` = |`grant`. `owner_id` = encoded index of the winner.

## Timing
- Grant latency: `req` sampled high at edge N gives `grant`/`busy` high after edge N (visible from cycle N+1).
- Data latency: the `req_data` value sampled at edge N appears on `disp_data` after that edge (one register stage). The first owned value appears on the same edge as `grant`.
- Ownership lasts at least HOLD_CYCLES cycles. A switch happens on the edge where the counter is 0 and another request is seen. The new grant is visible the next cycle; there are no gap cycles.
- A request that drops before it is granted is lost; no request memory is kept.
- With HOLD_CYCLES=1 the counter is always 0, so the arbiter re-arbitrates every cycle.
- Reset asserted mid-ownership: all outputs return to their reset values immediately (asynchronous). Arbitration restarts at index 0 after reset deasserts.
- Counter width: clog2(HOLD_CYCLES). The reload value must fit, with no wrap.

## Configuration
- `DISP_ARB_PREEMPT_EN` defined:
  - Requester 0 is urgent. If `req[0]` is high while another index owns the display, requester 0 takes the display on the next edge, even with hold time remaining.
  - The counter reloads and `last`=0.
  - While requester 0 owns the display it cannot be preempted.
- `DISP_ARB_PREEMPT_EN` not defined: pure round-robin with the full hold time; index 0 has no special priority.

## Test plan
All scenarios use N_REQ=4, HOLD_CYCLES=4.

- Single request: after reset, `req`=4'b0010 with data1=16'hBEEF → the next cycle shows `grant`=4'b0010, `owner_id`=1, `busy`=1, `disp_data`=16'hBEEF. Drop `req` at cycle 2 → `disp_data` stays 16'hBEEF, and `busy` falls 4 cycles after the grant.
- Round-robin: `req`=4'b1111 held continuously → `grant` sequence 0001, 0010, 0100, 1000, 0001. Each owner holds for exactly 4 cycles, with no idle cycles between owners.
- Hold protection: owner 2 granted; `req[3]` rises 1 cycle later → `grant` stays 4'b0100 until the counter expires, then becomes 4'b1000 on the next edge.
- Live update: owner 0 with `req[0]` high while data0 changes 16'h1234 → 16'h5678 → `disp_data` tracks it with 1-cycle latency. Data from non-owners never appears on `disp_data`.
- Async reset: assert `reset` mid-ownership between clock edges → `grant`=0, `busy`=0, `disp_data`=0 immediately. After release with `req`=4'b1010, index 1 wins first.
- Preempt (macro defined): owner 3 granted, `req[0]` rises 1 cycle later → `grant`=4'b0001 on the next edge. Without the macro, `grant` stays 4'b1000 for the full 4 cycles.

Source files
------------

// File: rtl/display_arbiter.sv
// display_arbiter: round-robin owner selection for the shared 4-digit hex display.
// Each grant is held for at least HOLD_CYCLES cycles.
// While the owner's request is high, the owner's data slice is forwarded to the display.
// Optional macro DISP_ARB_PREEMPT_EN: requester 0 becomes urgent and may take the
// display from any other owner at once.
module display_arbiter #(
    parameter int  N_REQ       = 4,
    parameter int  HOLD_CYCLES = 1000,
    localparam int IW          = $clog2(N_REQ)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [16*N_REQ-1:0]  i_req_data,
    output logic [N_REQ-1:0]     o_grant,
    output logic [IW-1:0]        o_owner_id,
    output logic                 o_busy,
    output logic [15:0]          o_disp_data
);

    localparam int               CW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0]    RELOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [N_REQ-1:0] ONE    = N_REQ'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_owner;
    logic [IW-1:0]    r_last;
    logic [N_REQ-1:0] r_grant;
    logic [15:0]      r_disp;

    state_t           w_state;
    logic [CW-1:0]    w_cnt;
    logic [IW-1:0]    w_owner;
    logic [IW-1:0]    w_last;
    logic [N_REQ-1:0] w_grant;
    logic [15:0]      w_disp;
    logic             w_load;
    logic [IW-1:0]    w_win;
    logic [N_REQ-1:0] w_others;
    logic             w_preempt;
    logic [15:0]      w_slice [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign w_slice[g] = i_req_data[16*g +: 16];
    end

`ifdef DISP_ARB_PREEMPT_EN
    // Requester 0 takes over from any other owner, even with hold time remaining.
    assign w_preempt = i_req[0] && (r_owner != '0);
`else
    assign w_preempt = 1'b0;
`endif

    // Return the first asserted index after 'base', wrapping modulo N_REQ.
    function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [IW-1:0]    base);
        logic [IW-1:0] pick;
        logic [IW-1:0] idx;
        logic [IW:0]   sum;
        logic          found;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            sum = {1'b0, base} + (IW+1)'(k);
            if (sum >= (IW+1)'(N_REQ)) begin
                sum = sum - (IW+1)'(N_REQ);
            end
            idx = sum[IW-1:0];
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Next-state logic: arbitration, hold countdown and display data selection.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_owner  = r_owner;
        w_last   = r_last;
        w_grant  = r_grant;
        w_disp   = r_disp;
        w_load   = 1'b0;
        w_win    = '0;
        w_others = i_req & ~r_grant;

        case (r_state)
            S_IDLE: begin
                if (|i_req) begin
                    w_load = 1'b1;
                    w_win  = rr_pick(i_req, r_last);
                end
            end
            S_OWN: begin
                if (w_preempt) begin
                    w_load = 1'b1;
                    w_win  = '0;
                end else if (r_cnt != '0) begin
                    w_cnt = r_cnt - 1'b1;
                    if (i_req[r_owner]) begin
                        w_disp = w_slice[r_owner];
                    end
                end else if (|w_others) begin
                    w_load = 1'b1;
                    w_win  = rr_pick(w_others, r_owner);
                end else if (i_req[r_owner]) begin
                    w_disp = w_slice[r_owner];
                end else begin
                    w_state = S_IDLE;
                    w_grant = '0;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_grant = '0;
            end
        endcase

        // A new grant shows the winner's data on the same edge as the grant itself.
        if (w_load) begin
            w_state = S_OWN;
            w_cnt   = RELOAD;
            w_owner = w_win;
            w_last  = w_win;
            w_grant = ONE << w_win;
            w_disp  = w_slice[w_win];
        end
    end

    // State register.
    // The pointer resets to N_REQ-1 so that the first search starts at index 0.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_owner <= '0;
            r_last  <= IW'(N_REQ - 1);
            r_grant <= '0;
            r_disp  <= 16'h0000;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_owner <= w_owner;
            r_last  <= w_last;
            r_grant <= w_grant;
            r_disp  <= w_disp;
        end
    end

    assign o_grant     = r_grant;
    assign o_owner_id  = r_owner;
    assign o_busy      = |r_grant;
    assign o_disp_data = r_disp;

endmodule

// File: tb/tb_display_arbiter.sv
// Testbench for display_arbiter with N_REQ=4 and HOLD_CYCLES=4.
// A behavioural model predicts the outputs after each edge and pushes them onto a scoreboard.
// A monitor pops each prediction and compares it with the DUT outputs.
module tb_display_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 4;
`ifdef DISP_ARB_PREEMPT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  g;
        logic [1:0]  id;
        logic        b;
        logic [15:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  o_grant;
    logic [1:0]  o_owner_id;
    logic        o_busy;
    logic [15:0] o_disp_data;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference state: current owner (-1 = none), cycles owned so far, and the round-robin pointer.
    int          m_owner;
    int          m_age;
    int          m_last;
    int          m_oid;
    logic [15:0] m_disp;

    display_arbiter #(.N_REQ(N), .HOLD_CYCLES(HOLD)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_req       (req),
        .i_req_data  (req_data),
        .o_grant     (o_grant),
        .o_owner_id  (o_owner_id),
        .o_busy      (o_busy),
        .o_disp_data (o_disp_data)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int base);
        for (int k = 1; k <= N; k++) begin
            if (r[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_last  = N - 1;
        m_oid   = 0;
        m_disp  = 16'h0000;
    endtask

    task automatic take(input int w, input logic [63:0] d);
        m_owner = w;
        m_last  = w;
        m_oid   = w;
        m_age   = 1;
        m_disp  = d[16*w +: 16];
    endtask

    task automatic model_step(input logic [3:0] r, input logic [63:0] d);
        logic [3:0] others;
        if (m_owner < 0) begin
            if (r != 4'b0) take(pick(r, m_last), d);
        end else if (PRE && r[0] && m_owner != 0) begin
            take(0, d);
        end else if (m_age < HOLD) begin
            m_age++;
            if (r[m_owner]) m_disp = d[16*m_owner +: 16];
        end else begin
            others = r & ~(4'b0001 << m_owner);
            if (others != 4'b0) take(pick(others, m_owner), d);
            else if (r[m_owner]) m_disp = d[16*m_owner +: 16];
            else m_owner = -1;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.g  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e.id = 2'(m_oid);
        e.b  = (m_owner >= 0);
        e.d  = m_disp;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // Drive one cycle of stimulus, predict the result of the next edge, then advance past that edge.
    task automatic cyc(input logic [3:0] r, input logic [63:0] d);
        req      = r;
        req_data = d;
        model_step(r, d);
        sb_q.push_back(model_out());
        @(posedge clk);
        #2;
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        req = 4'b0;
        sb_q.delete();
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Assert reset between edges; the outputs must clear without waiting for a clock edge.
    task automatic async_reset_mid(input string nm);
        #1;
        rst = 1'b1;
        #1;
        chk({nm, "_grant"}, 32'(o_grant), 32'h0);
        chk({nm, "_busy"},  32'(o_busy), 32'h0);
        chk({nm, "_disp"},  32'(o_disp_data), 32'h0);
        chk({nm, "_id"},    32'(o_owner_id), 32'h0);
        sb_q.delete();
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Monitor: compare DUT outputs with the oldest pending prediction just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                n_vec++;
                if ({o_grant, o_owner_id, o_busy, o_disp_data} !== e) begin
                    n_err++;
                    $display("FAIL scoreboard t=%0t: got g=%b id=%0d busy=%b disp=%h expected g=%b id=%0d busy=%b disp=%h",
                             $time, o_grant, o_owner_id, o_busy, o_disp_data, e.g, e.id, e.b, e.d);
                end
            end
        end
    end

    initial begin
        logic [3:0]  r;
        logic [63:0] d;
        int          len;
        int          waited;

        rst      = 1'b1;
        req      = 4'b0;
        req_data = 64'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("reset_grant", 32'(o_grant), 32'h0);
        chk("reset_busy",  32'(o_busy), 32'h0);
        chk("reset_disp",  32'(o_disp_data), 32'h0);
        chk("reset_id",    32'(o_owner_id), 32'h0);
        rst = 1'b0;

        // Single request, dropped at cycle 2.
        cyc(4'b0010, {16'h0, 16'h0, 16'hBEEF, 16'h0});
        chk("single_grant", 32'(o_grant), 32'h2);
        chk("single_id",    32'(o_owner_id), 32'h1);
        chk("single_disp",  32'(o_disp_data), 32'hBEEF);
        cyc(4'b0000, {16'h1111, 16'h2222, 16'h3333, 16'h4444});
        cyc(4'b0000, {16'h1111, 16'h2222, 16'h3333, 16'h4444});
        chk("single_hold_busy", 32'(o_busy), 32'h1);
        chk("single_freeze", 32'(o_disp_data), 32'hBEEF);
        cyc(4'b0000, 64'h0);
        cyc(4'b0000, 64'h0);
        chk("single_release", 32'(o_busy), 32'h0);

        // Round-robin with all requesters asserted continuously.
        sync_reset();
        for (int i = 1; i <= 17; i++) begin
            cyc(4'b1111, {$urandom, $urandom});
            if (i == 1)  chk("rr_0", 32'(o_grant), 32'h1);
            if (i == 5)  chk("rr_1", 32'(o_grant), 32'h2);
            if (i == 9)  chk("rr_2", 32'(o_grant), 32'h4);
            if (i == 13) chk("rr_3", 32'(o_grant), 32'h8);
            if (i == 17) chk("rr_wrap", 32'(o_grant), 32'h1);
        end

        // Hold protection: a competing request cannot take over before the hold time expires.
        sync_reset();
        cyc(4'b0100, {$urandom, $urandom});
        for (int i = 2; i <= 5; i++) begin
            cyc(4'b1100, {$urandom, $urandom});
            if (i == 4) chk("hold_keep", 32'(o_grant), 32'h4);
            if (i == 5) chk("hold_switch", 32'(o_grant), 32'h8);
        end

        // Live data update from the owner; data from non-owners must never appear.
        sync_reset();
        cyc(4'b0001, {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h1234});
        chk("live_first", 32'(o_disp_data), 32'h1234);
        cyc(4'b0001, {16'hDDDD, 16'hEEEE, 16'hFFFF, 16'h5678});
        chk("live_track", 32'(o_disp_data), 32'h5678);
        for (int i = 0; i < 3; i++) cyc(4'b0001, {$urandom, $urandom});

        // Preemption attempt by requester 0 against owner 3.
        sync_reset();
        cyc(4'b1000, {$urandom, $urandom});
        cyc(4'b1001, {$urandom, $urandom});
        chk("preempt", 32'(o_grant), PRE ? 32'h1 : 32'h8);
        for (int i = 0; i < 4; i++) cyc(4'b1001, {$urandom, $urandom});

        // Asynchronous reset in the middle of an ownership.
        sync_reset();
        cyc(4'b0100, {$urandom, $urandom});
        cyc(4'b0100, {$urandom, $urandom});
        async_reset_mid("areset");
        cyc(4'b1010, {$urandom, $urandom});
        chk("areset_restart", 32'(o_grant), 32'h2);

        // Randomised traffic: request patterns held for a few cycles, with occasional
        // single-bit flips and mid-cycle resets.
        for (int i = 0; i < 80; i++) begin
            r   = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 9) == 0) r[$urandom_range(0, 3)] = ~r[$urandom_range(0, 3)];
                d = {$urandom, $urandom};
                cyc(r, d);
            end
            if (i % 20 == 13) async_reset_mid("rand_areset");
        end
        req = 4'b0;

        waited = 0;
        while (sb_q.size() != 0 && waited < 5) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d predictions left, expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
